// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared widths, FSM states and requester ids for the register file write arbiter.
package regfile_arb_pkg;
  localparam int DEF_DATA_W   = 64;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_REGS = 32;
  typedef enum logic {S_INIT, S_RUN} state_e;
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;
endpackage

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant; on contention the requester not served last wins.
module rr_arb2 import regfile_arb_pkg::*; (
  input  logic       en_i,
  input  logic [1:0] valid_i,
  input  logic       rr_last_i,
  output logic [1:0] gnt_o
);
  assign gnt_o[REQ_ALU] = en_i & valid_i[REQ_ALU] & (~valid_i[REQ_MEM] | rr_last_i);
  assign gnt_o[REQ_MEM] = en_i & valid_i[REQ_MEM] & (~valid_i[REQ_ALU] | ~rr_last_i);
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: zero-fills the register file after reset, then round-robins its write port.
// Define WARB_ZERO_FILTER_EN to acknowledge rd==0 requests without writing x0.
module regfile_write_arbiter import regfile_arb_pkg::*; #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_rd,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_rd,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] RD,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic              init_done,
  output logic              grant_id
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, rd_q, rd_d, win_rd;
  logic [DATA_W-1:0] wd_q, wd_d, win_data;
  logic              we_q, we_d, gid_q, gid_d, rr_q, rr_d;
  logic [1:0]        gnt;
  logic              hs, win, keep;
  rr_arb2 u_arb (
    .en_i     (state_q == S_RUN),
    .valid_i  ({req1_valid, req0_valid}),
    .rr_last_i(rr_q),
    .gnt_o    (gnt)
  );
  assign req0_ready = gnt[REQ_ALU];
  assign req1_ready = gnt[REQ_MEM];
  assign hs         = |gnt;
  assign win        = gnt[REQ_MEM];
  assign win_rd     = win ? req1_rd : req0_rd;
  assign win_data   = win ? req1_data : req0_data;
`ifdef WARB_ZERO_FILTER_EN
  assign keep = |win_rd;
`else
  assign keep = 1'b1;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wd_d    = wd_q;
    we_d    = 1'b0;
    gid_d   = gid_q;
    rr_d    = rr_q;
    if (state_q == S_INIT) begin
      rd_d    = cnt_q;
      wd_d    = '0;
      we_d    = 1'b1;
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == LAST) ? S_RUN : S_INIT;
    end else if (hs) begin
      // a filtered x0 request still consumes its round-robin turn
      rr_d  = win;
      we_d  = keep;
      rd_d  = keep ? win_rd : rd_q;
      wd_d  = keep ? win_data : wd_q;
      gid_d = keep ? win : gid_q;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      rd_q    <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      gid_q   <= REQ_ALU;
      rr_q    <= REQ_MEM;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
    end
  end
  assign RD        = rd_q;
  assign WriteData = wd_q;
  assign RegWrite  = we_q;
  assign grant_id  = gid_q;
  assign init_done = state_q == S_RUN;
endmodule
